// File: rtl/boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_loader_pkg
//   Shared definitions for the UART program loader: frame-FSM and UART
//   receiver state encodings, the default frame start marker, field widths
//   and the 8-bit checksum helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package boot_loader_pkg;

    // Frame parser states (3-bit encoding, IDLE..ERR).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_H  = 3'd1,
        ST_LEN_L  = 3'd2,
        ST_DATA_H = 3'd3,
        ST_DATA_L = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } boot_state_e;

    // UART receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         WORD_W            = 16;   // RAM data width
    localparam int         LEN_W             = 16;   // frame length field width

    // Checksum accumulation stays in 8-bit modular arithmetic.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
//   Groups the loader's serial input, RAM write port and CPU control outputs.
//   Signals:
//     uart_rxd   serial input, idle high, 8N1, LSB first
//     mem_we     one-cycle RAM write strobe
//     mem_addr   RAM word address (ADDR_W bits)
//     mem_wdata  RAM write data (16 bits)
//     cpu_reset  high = CPU held in reset
//     boot_done  image loaded and checksum good
//     boot_err   framing, length or checksum failure
//   Modports:
//     master - the loader (drives RAM port and status, reads uart_rxd)
//     slave  - the system side (drives uart_rxd, consumes everything else)
// ---------------------------------------------------------------------------
interface boot_loader_if
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic                uart_rxd;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                cpu_reset;
    logic                boot_done;
    logic                boot_err;

    modport master (
        input  uart_rxd,
        output mem_we, mem_addr, mem_wdata, cpu_reset, boot_done, boot_err
    );

    modport slave (
        output uart_rxd,
        input  mem_we, mem_addr, mem_wdata, cpu_reset, boot_done, boot_err
    );

endinterface

// File: rtl/boot_loader_uart_rx.sv
// ---------------------------------------------------------------------------
// boot_loader_uart_rx
//   8N1 UART receiver: 2-flop synchroniser, falling-edge start detection,
//   mid-bit start re-check, mid-bit data and stop sampling.
//   Ports:
//     clock_50_b7a  in   system clock, rising edge
//     reset         in   asynchronous, active-high
//     rxd_i         in   raw serial line (idle high)
//     rx_data_o     out  received byte, valid with rx_valid_o
//     rx_valid_o    out  one-cycle pulse: byte received with good stop bit
//     rx_ferr_o     out  one-cycle pulse: stop bit sampled low
// ---------------------------------------------------------------------------
module boot_loader_uart_rx
    import boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock_50_b7a,
    input  logic       reset,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // State register; synchroniser flops reset to the idle (high) level so
    // leaving reset never looks like a start bit.
    always_ff @(posedge clock_50_b7a or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            st_q       <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                // Edge (not level) detect, so a line stuck low after a
                // framing error does not retrigger endlessly.
                if (rxd_prev_q && !rxd_sync_q) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    st_d  = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};   // LSB arrives first
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (rxd_sync_q) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        rx_data_o  = shift_q;
        rx_valid_o = valid_q;
        rx_ferr_o  = ferr_q;
    end

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//   UART program loader. Receives a framed image
//     SYNC, LEN_H, LEN_L, N x (DATA_H, DATA_L), CSUM
//   writes each 16-bit word into the RAM write port, and releases the CPU
//   from reset once the 8-bit sum of LEN_H..CSUM is zero.
//   Ports:
//     clock_50_b7a  in   system clock, rising edge
//     reset         in   asynchronous, active-high; clears all state
//     bus           boot_loader_if.master:
//                     uart_rxd in; mem_we, mem_addr, mem_wdata,
//                     cpu_reset, boot_done, boot_err out
// ---------------------------------------------------------------------------
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic          clock_50_b7a,
    input  logic          reset,
    boot_loader_if.master bus
);

    // Largest legal image: a full address space.
    localparam logic [31:0] MAX_WORDS = 32'(2 ** ADDR_W);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;

    boot_loader_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock_50_b7a (clock_50_b7a),
        .reset        (reset),
        .rxd_i        (bus.uart_rxd),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ferr_o    (rx_ferr)
    );

    boot_state_e         state_q, state_d;
    logic [7:0]          sum_q, sum_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    wcnt_q, wcnt_d;
    logic [7:0]          data_hi_q, data_hi_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic [7:0]          sum_next;
    logic [LEN_W-1:0]    n_words;
    logic                in_frame;

    assign sum_next = sum8(sum_q, rx_data);
    assign n_words  = {len_hi_q, rx_data};
    // States where a framing error aborts the load.
    assign in_frame = (state_q == ST_LEN_H)  || (state_q == ST_LEN_L) ||
                      (state_q == ST_DATA_H) || (state_q == ST_DATA_L) ||
                      (state_q == ST_CSUM);

    // State register.
    always_ff @(posedge clock_50_b7a or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sum_q     <= '0;
            len_hi_q  <= '0;
            len_q     <= '0;
            wcnt_q    <= '0;
            data_hi_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            data_hi_q <= data_hi_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic: frame parsing, checksum, word counter, RAM port.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        data_hi_d = data_hi_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        // Address advances the cycle after each strobe. Only one byte is
        // ever in flight, so this never collides with the SYNC clear below.
        addr_d    = we_q ? addr_q + ADDR_W'(1) : addr_q;

        if (rx_ferr) begin
            if (in_frame) begin
                state_d = ST_ERR;
            end
        end else if (rx_valid) begin
            unique case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ST_LEN_H;
                        sum_d   = '0;
                        wcnt_d  = '0;
                        addr_d  = '0;
                    end
                end
                ST_LEN_H: begin
                    len_hi_d = rx_data;
                    sum_d    = sum_next;
                    state_d  = ST_LEN_L;
                end
                ST_LEN_L: begin
                    sum_d  = sum_next;
                    len_d  = n_words;
                    wcnt_d = '0;
                    if (32'(n_words) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (n_words == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_H;
                    end
                end
                ST_DATA_H: begin
                    data_hi_d = rx_data;
                    sum_d     = sum_next;
                    state_d   = ST_DATA_L;
                end
                ST_DATA_L: begin
                    sum_d   = sum_next;
                    wdata_d = {data_hi_q, rx_data};
                    we_d    = 1'b1;
                    wcnt_d  = wcnt_q + LEN_W'(1);
                    state_d = (wcnt_q + LEN_W'(1) == len_q) ? ST_CSUM : ST_DATA_H;
                end
                ST_CSUM: begin
                    sum_d   = sum_next;
                    state_d = (sum_next == 8'd0) ? ST_DONE : ST_ERR;
                end
                ST_DONE: begin
                    state_d = ST_DONE;   // locked until reset
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: RAM port straight from its registers, status decoded from state.
    always_comb begin
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.cpu_reset = (state_q != ST_DONE);
        bus.boot_done = (state_q == ST_DONE);
        bus.boot_err  = (state_q == ST_ERR);
    end

endmodule
